// File: rtl/sd_req_arbiter.sv
// ---------------------------------------------------------------------------
// sd_req_arbiter
//
// Shares a single mist_io SD sector interface between two requesters.
// Each requester raises a level read or write request with a sector address;
// the arbiter grants one of them (round-robin on a tie). It then latches the
// address and the operation, and drives sd_rd/sd_wr until mist_io
// acknowledges. While mist_io holds sd_ack, buffer write strobes go only to
// the granted requester. When sd_ack falls, the arbiter pulses that
// requester's done output.
//
// Optional feature (macro SD_REQ_ARBITER_TIMEOUT_EN):
//   When defined, a request that waits TIMEOUT cycles without sd_ack is
//   abandoned. sd_rd/sd_wr drop, and done and err pulse together for the
//   granted requester. When undefined, the arbiter waits for sd_ack
//   indefinitely and both err outputs are tied low.
//
// Parameters:
//   TIMEOUT       maximum clk_sys cycles spent waiting for sd_ack
//
// Ports:
//   clk_sys       system clock, all logic on its rising edge
//   reset         synchronous, active-high reset
//   reqN_rd/wr    level read / write request from requester N (rd wins)
//   reqN_lba      sector address of requester N, held with the request
//   reqN_done     one-cycle completion pulse to requester N
//   reqN_err      one-cycle error pulse, coincident with reqN_done
//   reqN_buff_wr  sd_buff_wr routed to requester N while it is transferring
//   sd_rd/sd_wr   command to mist_io
//   sd_lba        latched sector address to mist_io
//   sd_ack        mist_io acknowledge, high for the whole transfer
//   sd_buff_wr    mist_io buffer write strobe
//   busy          high whenever the arbiter is not idle
//   grant         index of the requester currently served
// ---------------------------------------------------------------------------
module sd_req_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd2700000
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic        req0_rd,
    input  logic        req0_wr,
    input  logic [31:0] req0_lba,
    output logic        req0_done,
    output logic        req0_err,
    output logic        req0_buff_wr,

    input  logic        req1_rd,
    input  logic        req1_wr,
    input  logic [31:0] req1_lba,
    output logic        req1_done,
    output logic        req1_err,
    output logic        req1_buff_wr,

    output logic        sd_rd,
    output logic        sd_wr,
    output logic [31:0] sd_lba,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,

    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_reg;
    logic        sd_rd_reg;
    logic        sd_wr_reg;
    logic [31:0] sd_lba_reg;
    logic        grant_reg;
    logic        last_served_reg;
    logic [1:0]  done_reg;

    // Requester inputs gathered into vectors so both sides share one path.
    logic [1:0]  req_rd;
    logic [1:0]  req_wr;
    logic [1:0]  pending;
    logic [31:0] req_lba [2];

    assign req_rd     = {req1_rd, req0_rd};
    assign req_wr     = {req1_wr, req0_wr};
    assign pending    = req_rd | req_wr;
    assign req_lba[0] = req0_lba;
    assign req_lba[1] = req1_lba;

    // Arbitration: a lone requester wins outright. On a tie, the requester
    // that was not served last wins.
    logic grant_next;

    always_comb begin
        grant_next = 1'b0;
        if (pending == 2'b11) begin
            grant_next = ~last_served_reg;
        end else if (pending == 2'b10) begin
            grant_next = 1'b1;
        end
    end

`ifdef SD_REQ_ARBITER_TIMEOUT_EN
    logic [23:0] wait_cnt_reg;
    logic [1:0]  err_reg;
    logic        wait_expired;

    // Compare one bit wider so the +1 cannot wrap back to zero.
    assign wait_expired = ({1'b0, wait_cnt_reg} + 25'd1) >= {1'b0, TIMEOUT};
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            sd_rd_reg       <= 1'b0;
            sd_wr_reg       <= 1'b0;
            sd_lba_reg      <= 32'd0;
            grant_reg       <= 1'b0;
            last_served_reg <= 1'b1;
            done_reg        <= 2'b00;
`ifdef SD_REQ_ARBITER_TIMEOUT_EN
            wait_cnt_reg    <= 24'd0;
            err_reg         <= 2'b00;
`endif
        end else begin
            // Completion pulses last exactly one cycle.
            done_reg <= 2'b00;
`ifdef SD_REQ_ARBITER_TIMEOUT_EN
            err_reg  <= 2'b00;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (|pending) begin
                        // Take a snapshot of the winner's request. Later
                        // changes on its inputs have no effect until the
                        // next grant.
                        grant_reg  <= grant_next;
                        sd_lba_reg <= req_lba[grant_next];
                        sd_rd_reg  <= req_rd[grant_next];
                        sd_wr_reg  <= ~req_rd[grant_next];
`ifdef SD_REQ_ARBITER_TIMEOUT_EN
                        wait_cnt_reg <= 24'd0;
`endif
                        state_reg  <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (sd_ack) begin
                        // mist_io has taken the command; withdraw it now.
                        sd_rd_reg <= 1'b0;
                        sd_wr_reg <= 1'b0;
                        state_reg <= ST_XFER;
                    end
`ifdef SD_REQ_ARBITER_TIMEOUT_EN
                    else if (wait_expired) begin
                        sd_rd_reg           <= 1'b0;
                        sd_wr_reg           <= 1'b0;
                        done_reg[grant_reg] <= 1'b1;
                        err_reg[grant_reg]  <= 1'b1;
                        last_served_reg     <= grant_reg;
                        state_reg           <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 24'd1;
                    end
`endif
                end

                ST_XFER: begin
                    if (!sd_ack) begin
                        // done is high for the whole DONE cycle.
                        done_reg[grant_reg] <= 1'b1;
                        state_reg           <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    last_served_reg <= grant_reg;
                    state_reg       <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-requester outputs. Buffer strobes pass through combinationally,
    // but only while a transfer is in progress and only to the granted side.
    logic [1:0] buff_wr_vec;
    logic [1:0] err_vec;

`ifdef SD_REQ_ARBITER_TIMEOUT_EN
    assign err_vec = err_reg;
`else
    assign err_vec = 2'b00;

    // TIMEOUT only matters when the wait limit is built in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            assign buff_wr_vec[gi] = (state_reg == ST_XFER) &&
                                     (grant_reg == 1'(gi)) &&
                                     sd_buff_wr;
        end
    endgenerate

    assign req0_done    = done_reg[0];
    assign req1_done    = done_reg[1];
    assign req0_err     = err_vec[0];
    assign req1_err     = err_vec[1];
    assign req0_buff_wr = buff_wr_vec[0];
    assign req1_buff_wr = buff_wr_vec[1];

    assign sd_rd  = sd_rd_reg;
    assign sd_wr  = sd_wr_reg;
    assign sd_lba = sd_lba_reg;
    assign busy   = (state_reg != ST_IDLE);
    assign grant  = grant_reg;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_req_arbiter
//
// Directed scenarios followed by randomized transactions. The expected
// grant, operation, address, strobe routing and done pulses come from a
// transaction-level model. That model holds the identity of the requester
// served last and applies the round-robin and read-over-write rules to the
// request levels present at grant time.
// ---------------------------------------------------------------------------
module tb_sd_req_arbiter;

    localparam logic [23:0] TB_TIMEOUT = 24'd16;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        req0_rd = 1'b0, req0_wr = 1'b0;
    logic        req1_rd = 1'b0, req1_wr = 1'b0;
    logic [31:0] req0_lba = 32'd0, req1_lba = 32'd0;
    logic        req0_done, req0_err, req0_buff_wr;
    logic        req1_done, req1_err, req1_buff_wr;
    logic        sd_rd, sd_wr;
    logic [31:0] sd_lba;
    logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
    logic        busy, grant;

    sd_req_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req0_rd      (req0_rd),
        .req0_wr      (req0_wr),
        .req0_lba     (req0_lba),
        .req0_done    (req0_done),
        .req0_err     (req0_err),
        .req0_buff_wr (req0_buff_wr),
        .req1_rd      (req1_rd),
        .req1_wr      (req1_wr),
        .req1_lba     (req1_lba),
        .req1_done    (req1_done),
        .req1_err     (req1_err),
        .req1_buff_wr (req1_buff_wr),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_lba       (sd_lba),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .busy         (busy),
        .grant        (grant)
    );

    always #5 clk_sys = ~clk_sys;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model state: the requester served last (reset value 1).
    int last_served = 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule. A lone requester wins. On a tie, the requester not
    // served last wins.
    function automatic int pick(input bit p0, input bit p1, input int last);
        if (p0 && p1) return 1 - last;
        if (p1)       return 1;
        return 0;
    endfunction

    // Run one full transaction with the request levels currently driven.
    // ack_dly sets the idle cycles in REQ before sd_ack. xfer_len sets the
    // XFER cycles with sd_ack high, and n_strobe sets the buff_wr strobes
    // within them. mutate drops the request and changes the lba mid-XFER.
    task automatic do_txn(input int ack_dly, input int xfer_len,
                          input int n_strobe, input bit mutate);
        bit          p0, p1, exp_rd, found;
        int          g, cnt0, cnt1;
        logic [31:0] exp_lba;

        p0      = req0_rd | req0_wr;
        p1      = req1_rd | req1_wr;
        g       = pick(p0, p1, last_served);
        exp_rd  = (g == 0) ? req0_rd : req1_rd;
        exp_lba = (g == 0) ? req0_lba : req1_lba;

        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            found = sd_rd | sd_wr;
        end
        check_bit("grant_seen", found, 1'b1);
        if (!found) return;

        check_bit("grant_idx", grant, (g == 1));
        check_bit("sd_rd_op", sd_rd, exp_rd);
        check_bit("sd_wr_op", sd_wr, !exp_rd);
        check_word("sd_lba_req", sd_lba, exp_lba);
        check_bit("busy_req", busy, 1'b1);

        // A strobe before the transfer starts must not reach anyone.
        if (ack_dly > 0) begin
            sd_buff_wr = 1'b1;
            #1;
            check_bit("early_buff_wr0", req0_buff_wr, 1'b0);
            check_bit("early_buff_wr1", req1_buff_wr, 1'b0);
            sd_buff_wr = 1'b0;
        end
        repeat (ack_dly) tick();
        check_bit("op_held", sd_rd | sd_wr, 1'b1);

        sd_ack = 1'b1;
        tick();
        check_bit("rd_drop_on_ack", sd_rd, 1'b0);
        check_bit("wr_drop_on_ack", sd_wr, 1'b0);
        check_bit("busy_xfer", busy, 1'b1);

        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < xfer_len; i++) begin
            if (mutate && i == xfer_len / 2) begin
                if (g == 0) begin
                    req0_rd = 1'b0; req0_wr = 1'b0; req0_lba = ~req0_lba;
                end else begin
                    req1_rd = 1'b0; req1_wr = 1'b0; req1_lba = ~req1_lba;
                end
            end
            sd_buff_wr = (i < n_strobe);
            #1;
            cnt0 += int'(req0_buff_wr);
            cnt1 += int'(req1_buff_wr);
            tick();
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        tick();

        check_bit("done0_pulse", req0_done, (g == 0));
        check_bit("done1_pulse", req1_done, (g == 1));
        check_bit("err0_clear", req0_err, 1'b0);
        check_bit("err1_clear", req1_err, 1'b0);
        check_word("sd_lba_kept", sd_lba, exp_lba);
        check_word("buff_wr_cnt0", 32'(cnt0), (g == 0) ? 32'(n_strobe) : 32'd0);
        check_word("buff_wr_cnt1", 32'(cnt1), (g == 1) ? 32'(n_strobe) : 32'd0);

        tick();
        check_bit("done0_one_cycle", req0_done, 1'b0);
        check_bit("done1_one_cycle", req1_done, 1'b0);
        check_bit("idle_after_done", busy, 1'b0);
        last_served = g;
    endtask

    initial begin
        bit found;
        int r, xl, n;
        bit saw_done;

        // Reset state, including a strobe that must be ignored.
        sd_buff_wr = 1'b1;
        repeat (3) tick();
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_sd_rd", sd_rd, 1'b0);
        check_bit("rst_sd_wr", sd_wr, 1'b0);
        check_word("rst_sd_lba", sd_lba, 32'd0);
        check_bit("rst_grant", grant, 1'b0);
        check_bit("rst_done0", req0_done, 1'b0);
        check_bit("rst_done1", req1_done, 1'b0);
        check_bit("rst_buff_wr0", req0_buff_wr, 1'b0);
        check_bit("rst_buff_wr1", req1_buff_wr, 1'b0);
        sd_buff_wr = 1'b0;
        reset = 1'b0;
        tick();
        check_bit("idle_no_req", busy, 1'b0);

        // Simultaneous requests held: req0 first, then alternation.
        req0_rd = 1'b1; req0_lba = 32'h0000_00A0;
        req1_wr = 1'b1; req1_lba = 32'h0000_00B1;
        do_txn(2, 4, 2, 1'b0);
        do_txn(1, 3, 3, 1'b0);
        do_txn(0, 2, 1, 1'b0);
        req0_rd = 1'b0; req1_wr = 1'b0;

        // Single read, ack three cycles later, held ten cycles.
        req0_rd = 1'b1; req0_lba = 32'h0000_0012;
        do_txn(3, 10, 0, 1'b0);
        req0_rd = 1'b0;

        // Full 512-strobe sector to requester 1.
        req1_rd = 1'b1; req1_lba = 32'h0001_2345;
        do_txn(1, 520, 512, 1'b0);
        req1_rd = 1'b0;

        // Request dropped and address changed mid-transfer.
        req1_wr = 1'b1; req1_lba = 32'h5555_AAAA;
        do_txn(2, 6, 3, 1'b1);
        req1_wr = 1'b0;

        // Reset in XFER, then req0 must win the next tie.
        req1_rd = 1'b1; req1_lba = 32'h0000_0777;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            found = sd_rd;
        end
        check_bit("rst_xfer_grant_seen", found, 1'b1);
        sd_ack = 1'b1;
        tick();
        tick();
        reset   = 1'b1;
        sd_ack  = 1'b0;
        req1_rd = 1'b0;
        tick();
        check_bit("rst_xfer_busy", busy, 1'b0);
        check_bit("rst_xfer_sd_rd", sd_rd, 1'b0);
        check_bit("rst_xfer_done0", req0_done, 1'b0);
        check_bit("rst_xfer_done1", req1_done, 1'b0);
        reset = 1'b0;
        last_served = 1;
        tick();
        check_bit("rst_xfer_late_done1", req1_done, 1'b0);
        req0_wr = 1'b1; req0_lba = 32'h0000_0C0C;
        req1_rd = 1'b1; req1_lba = 32'h0000_0D0D;
        do_txn(1, 2, 1, 1'b0);
        req0_wr = 1'b0; req1_rd = 1'b0;

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            r  = int'($urandom_range(1, 15));
            req0_rd  = r[0];
            req0_wr  = r[1];
            req1_rd  = r[2];
            req1_wr  = r[3];
            req0_lba = $urandom;
            req1_lba = $urandom;
            xl = int'($urandom_range(1, 12));
            do_txn(int'($urandom_range(0, 10)), xl, int'($urandom_range(0, xl)),
                   (xl >= 2) && ($urandom_range(0, 1) == 1));
            req0_rd = 1'b0; req0_wr = 1'b0; req1_rd = 1'b0; req1_wr = 1'b0;
        end

        // sd_ack never arrives.
        req0_rd = 1'b1; req0_lba = 32'h0000_0037;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            found = sd_rd;
        end
        check_bit("to_grant_seen", found, 1'b1);
`ifdef SD_REQ_ARBITER_TIMEOUT_EN
        n = 0;
        while (sd_rd && n < 40) begin
            n++;
            tick();
        end
        check_word("to_req_cycles", 32'(n), 32'(TB_TIMEOUT));
        check_bit("to_done0", req0_done, 1'b1);
        check_bit("to_err0", req0_err, 1'b1);
        check_bit("to_done1", req1_done, 1'b0);
        check_bit("to_busy", busy, 1'b0);
        req0_rd = 1'b0;
        last_served = 0;
        tick();
        check_bit("to_done0_one_cycle", req0_done, 1'b0);
        check_bit("to_err0_one_cycle", req0_err, 1'b0);
`else
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_done = saw_done | req0_done | req0_err;
        end
        check_bit("nto_sd_rd_held", sd_rd, 1'b1);
        check_bit("nto_no_done", saw_done, 1'b0);
        reset   = 1'b1;
        req0_rd = 1'b0;
        tick();
        reset = 1'b0;
        last_served = 1;
        tick();
        check_bit("nto_idle_after_reset", busy, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 24'd2700000, max clk_sys cycles in REQ awaiting sd_ack (100 ms at 27 MHz).
REQ-002 clk_sys  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_rd / req1_rd  input  1  level sector-read request from requester 0 / 1.
REQ-005 req0_wr / req1_wr  input  1  level sector-write request from requester 0 / 1.
REQ-006 req0_lba / req1_lba  input  32  sector address, stable while request held.
REQ-007 req0_done / req1_done  output  1  one-cycle completion pulse.
REQ-008 req0_err / req1_err  output  1  one-cycle error pulse, coincident with done.
REQ-009 req0_buff_wr / req1_buff_wr  output  1  sd_buff_wr routed to the granted requester.
REQ-010 sd_rd / sd_wr  output  1  command to mist_io.
REQ-011 sd_lba  output  32  latched sector address to mist_io.
REQ-012 sd_ack  input  1  mist_io transfer acknowledge, high for whole transfer.
REQ-013 sd_buff_wr  input  1  mist_io buffer write strobe.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 grant  output  1  index of requester currently served (0 or 1).

Function
REQ-016 FSM states SHALL be IDLE, REQ, XFER, DONE.
REQ-017 IDLE: requester is pending if rd or wr high; rd SHALL take priority over wr within one requester.
REQ-018 IDLE, one pending: grant it; both pending: grant the requester not served last (round-robin).
REQ-019 On grant, lba, op (rd/wr) and grant index SHALL be latched in the same edge; next state REQ.
REQ-020 REQ: exactly the latched one of sd_rd/sd_wr SHALL be high; sd_lba SHALL equal latched lba.
REQ-021 REQ -> XFER on first cycle sd_ack sampled high; sd_rd/sd_wr SHALL drop on that same edge.
REQ-022 XFER: reqN_buff_wr SHALL equal sd_buff_wr combinationally for granted N, other requester 0.
REQ-023 XFER -> DONE when sd_ack sampled low.
REQ-024 DONE: reqN_done high one cycle for granted N; update last-served; next state IDLE.
REQ-025 Earliest next grant SHALL be the cycle after DONE (IDLE lasts at least one cycle).
REQ-026 Requester dropping its request after grant SHALL NOT abort; transfer completes and done pulses.
REQ-027 Request changes (lba/op) after grant SHALL be ignored until the next grant.
REQ-028 sd_buff_wr outside XFER SHALL be discarded (both reqN_buff_wr 0).

Reset
REQ-029 Reset SHALL force IDLE, sd_rd=0, sd_wr=0, sd_lba=0, all done/err/buff_wr=0, busy=0, grant=0, last-served=1 (requester 0 wins first tie).
REQ-030 Reset mid-transfer SHALL drop sd_rd/sd_wr at that edge with no done or err pulse.

Configuration
REQ-031 Macro SD_REQ_ARBITER_TIMEOUT_EN defined: 24-bit counter cleared on entering REQ, increments each REQ cycle; reaching TIMEOUT without sd_ack SHALL drop sd_rd/sd_wr, pulse done and err for granted requester, go IDLE, update last-served.
REQ-032 Macro undefined: REQ waits indefinitely; no counter instantiated; req0_err and req1_err tied 0.

Verification
REQ-033 req0_rd=1, lba=0x12; sd_ack high 3 cycles after sd_rd, held 10 cycles -> sd_lba=0x12, sd_rd drops on ack edge, req0_done one pulse, req1_done 0.
REQ-034 req0_rd and req1_wr raised same cycle, held -> req0 served first, then req1 with sd_wr=1, then req0 again (alternation).
REQ-035 XFER with 512 sd_buff_wr strobes, grant=1 -> req1_buff_wr count 512, req0_buff_wr count 0.
REQ-036 req1_wr drops and lba changes mid-XFER -> sd_lba unchanged, req1_done still pulses.
REQ-037 TIMEOUT=16, macro defined, sd_ack never asserted -> sd_rd drops after 16 REQ cycles, req0_done and req0_err pulse together; macro undefined -> sd_rd stays high.
REQ-038 reset asserted in XFER -> next cycle busy=0, sd_rd=0, no done pulse; req0 wins subsequent tie.
